wb_flush_ctrl: RTL and testbench

//   Exception/ERTN sequencer behind the WB stage. Samples a trap or ertn retiring in WB.

---
 rtl/wb_flush_ctrl.sv | 117 +++++++++++
 tb/tb_wb_flush_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wb_flush_ctrl.sv
// wb_flush_ctrl: trap / ertn sequencer sitting behind the WB stage.
//
// A trap or ertn retiring in WB is captured. The controller then pulses a single
// commit to the CSR file and holds a global flush for FLUSH_CYCLES cycles. After
// that it offers the redirect target (EENTRY for a trap, ERA for ertn) to IF over
// a valid/ready handshake. Only one event is handled at a time, so each trap
// produces exactly one redirect.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wb_valid, wb_ex, ertn_in      WB retire qualifiers
//   wb_pc, wb_ecode, wb_esubcode  trap information from WB
//   wb_vaddr                      faulting address (BADV source)
//   csr_eentry, csr_era           redirect target sources
//   redirect_ready                IF accepts the redirect
//   flush, busy                   pipeline kill / controller active
//   ex_commit, ertn_commit        one-cycle CSR update pulses
//   ex_pc, ex_ecode, ex_esubcode  captured trap information
//   ex_vaddr                      captured faulting address
//   redirect_valid, redirect_pc   redirect offer to IF
module wb_flush_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic        wb_ex,
  input  logic        ertn_in,
  input  logic [31:0] wb_pc,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_vaddr,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  input  logic        redirect_ready,
  output logic        flush,
  output logic        busy,
  output logic        ex_commit,
  output logic [31:0] ex_pc,
  output logic [5:0]  ex_ecode,
  output logic [8:0]  ex_esubcode,
  output logic [31:0] ex_vaddr,
  output logic        ertn_commit,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StFlush, StRedir} state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [31:0]     target;
  logic            trigger;

  assign trigger = wb_valid & (wb_ex | ertn_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= StIdle;
      cnt            <= '0;
      target         <= '0;
      flush          <= 1'b0;
      busy           <= 1'b0;
      ex_commit      <= 1'b0;
      ertn_commit    <= 1'b0;
      ex_pc          <= '0;
      ex_ecode       <= '0;
      ex_esubcode    <= '0;
      ex_vaddr       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      // Commit pulses last a single cycle.
      ex_commit   <= 1'b0;
      ertn_commit <= 1'b0;
      unique case (state)
        StIdle: begin
          if (trigger) begin
            ex_pc       <= wb_pc;
            ex_ecode    <= wb_ecode;
            ex_esubcode <= wb_esubcode;
            ex_vaddr    <= wb_vaddr;
            // An exception outranks a simultaneous ertn.
            target      <= wb_ex ? csr_eentry : csr_era;
            ex_commit   <= wb_ex;
            ertn_commit <= ~wb_ex;
            cnt         <= CntW'(FLUSH_CYCLES - 1);
            flush       <= 1'b1;
            busy        <= 1'b1;
            state       <= StFlush;
          end
        end
        StFlush: begin
          if (cnt == '0) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
            state          <= StRedir;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StRedir: begin
          if (redirect_valid && redirect_ready) begin
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            busy           <= 1'b0;
            state          <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_flush_ctrl.sv
module tb_wb_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_ex, ertn_in;
  logic [31:0] wb_pc, wb_vaddr, csr_eentry, csr_era;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        redirect_ready;
  logic        flush, busy, ex_commit, ertn_commit, redirect_valid;
  logic [31:0] ex_pc, ex_vaddr, redirect_pc;
  logic [5:0]  ex_ecode;
  logic [8:0]  ex_esubcode;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_flush_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_valid       (wb_valid),
    .wb_ex          (wb_ex),
    .ertn_in        (ertn_in),
    .wb_pc          (wb_pc),
    .wb_ecode       (wb_ecode),
    .wb_esubcode    (wb_esubcode),
    .wb_vaddr       (wb_vaddr),
    .csr_eentry     (csr_eentry),
    .csr_era        (csr_era),
    .redirect_ready (redirect_ready),
    .flush          (flush),
    .busy           (busy),
    .ex_commit      (ex_commit),
    .ex_pc          (ex_pc),
    .ex_ecode       (ex_ecode),
    .ex_esubcode    (ex_esubcode),
    .ex_vaddr       (ex_vaddr),
    .ertn_commit    (ertn_commit),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".flush"}, {31'd0, flush}, 32'd0);
    check_eq({tag, ".busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, ".commits"}, {30'd0, ex_commit, ertn_commit}, 32'd0);
    check_eq({tag, ".rv"}, {31'd0, redirect_valid}, 32'd0);
    check_eq({tag, ".rpc"}, redirect_pc, 32'd0);
    check_eq({tag, ".ex_pc"}, ex_pc, 32'd0);
    check_eq({tag, ".ex_code"}, {17'd0, ex_esubcode, ex_ecode}, 32'd0);
    check_eq({tag, ".ex_vaddr"}, ex_vaddr, 32'd0);
  endtask

  // Drives one event from the currently set wb_pc/ecode/... and follows it to
  // the IDLE return. While busy a different trap is held on WB to prove it is
  // ignored; IF stalls for 'stall' cycles once the redirect is offered.
  task automatic run_event(input string tag, input logic ex, input logic ertn, input int stall,
                           input logic [31:0] exp_rpc);
    logic [31:0] pc0, va0, rpc0;
    logic [5:0]  ec0;
    logic [8:0]  sc0;
    int n_ex, n_ertn, dwell, guard;
    pc0 = wb_pc; ec0 = wb_ecode; sc0 = wb_esubcode; va0 = wb_vaddr;
    wb_valid = 1'b1; wb_ex = ex; ertn_in = ertn; redirect_ready = 1'b0;
    tick();
    // T+1
    check_eq({tag, ".t1_flush"}, {30'd0, flush, busy}, 32'd3);
    check_eq({tag, ".t1_ex_pc"}, ex_pc, pc0);
    check_eq({tag, ".t1_codes"}, {17'd0, ex_esubcode, ex_ecode}, {17'd0, sc0, ec0});
    check_eq({tag, ".t1_vaddr"}, ex_vaddr, va0);
    check_eq({tag, ".t1_rv"}, {31'd0, redirect_valid}, 32'd0);
    n_ex = int'(ex_commit); n_ertn = int'(ertn_commit);
    wb_pc = 32'hDEAD_0000; wb_ecode = 6'h3F; wb_esubcode = 9'h1FF; wb_vaddr = 32'hBAD0_BAD0;
    wb_valid = 1'b1; wb_ex = 1'b1; ertn_in = 1'b0;
    dwell = 1; guard = 0;
    while (!redirect_valid && guard < 10) begin
      tick();
      guard++;
      n_ex += int'(ex_commit); n_ertn += int'(ertn_commit);
      check_eq({tag, ".flush_held"}, {31'd0, flush}, 32'd1);
      if (!redirect_valid) dwell++;
    end
    check_eq({tag, ".rv_seen"}, {31'd0, redirect_valid}, 32'd1);
    check_eq({tag, ".dwell"}, dwell, 32'd2);
    check_eq({tag, ".rpc"}, redirect_pc, exp_rpc);
    rpc0 = redirect_pc;
    for (int i = 0; i < stall; i++) begin
      tick();
      n_ex += int'(ex_commit); n_ertn += int'(ertn_commit);
      check_eq({tag, ".stall_hold"}, {29'd0, redirect_valid, flush, busy}, 32'd7);
      check_eq({tag, ".stall_rpc"}, redirect_pc, rpc0);
    end
    redirect_ready = 1'b1;
    wb_valid = 1'b0; wb_ex = 1'b0; ertn_in = 1'b0;
    tick();
    n_ex += int'(ex_commit); n_ertn += int'(ertn_commit);
    check_eq({tag, ".done"}, {29'd0, redirect_valid, flush, busy}, 32'd0);
    check_eq({tag, ".n_ex"}, n_ex, ex ? 32'd1 : 32'd0);
    check_eq({tag, ".n_ertn"}, n_ertn, (!ex && ertn) ? 32'd1 : 32'd0);
    check_eq({tag, ".kept_pc"}, ex_pc, pc0);
    check_eq({tag, ".kept_ec"}, {26'd0, ex_ecode}, {26'd0, ec0});
    redirect_ready = 1'b0;
  endtask

  initial begin
    int n_bad;
    rst = 1'b1; wb_valid = 1'b0; wb_ex = 1'b0; ertn_in = 1'b0;
    wb_pc = '0; wb_ecode = '0; wb_esubcode = '0; wb_vaddr = '0;
    csr_eentry = 32'h1C00_8000; csr_era = 32'h1C00_0100; redirect_ready = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Trap into EENTRY.
    wb_pc = 32'h1C00_0010; wb_ecode = 6'h0B; wb_esubcode = 9'h005; wb_vaddr = 32'h0000_1234;
    run_event("trap", 1'b1, 1'b0, 0, 32'h1C00_8000);
    // ertn back to ERA, issued in the first IDLE cycle after the previous redirect.
    wb_pc = 32'h1C00_8040; wb_ecode = 6'h00; wb_esubcode = 9'h000; wb_vaddr = 32'h0;
    run_event("ertn", 1'b0, 1'b1, 0, 32'h1C00_0100);
    // Both set: handled as an exception.
    wb_pc = 32'h1C00_0200; wb_ecode = 6'h08; wb_esubcode = 9'h001; wb_vaddr = 32'h5555_AAAA;
    run_event("both", 1'b1, 1'b1, 0, 32'h1C00_8000);
    // IF stalls 5 cycles while a new trap sits on WB.
    wb_pc = 32'h1C00_0300; wb_ecode = 6'h01; wb_esubcode = 9'h100; wb_vaddr = 32'h8000_0004;
    run_event("stall", 1'b1, 1'b0, 5, 32'h1C00_8000);

    // Reset in the second FLUSH cycle aborts the sequence.
    tick();
    wb_pc = 32'h1C00_0400; wb_ecode = 6'h02;
    wb_valid = 1'b1; wb_ex = 1'b1; redirect_ready = 1'b1;
    tick();
    wb_valid = 1'b0; wb_ex = 1'b0;
    tick();
    check_eq("rst_mid.pre", {30'd0, flush, redirect_valid}, 32'd2);
    rst = 1'b1;
    tick();
    check_all_zero("rst_mid");
    rst = 1'b0;
    n_bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_bad += int'(redirect_valid) + int'(ex_commit) + int'(ertn_commit) + int'(busy);
    end
    check_eq("rst_mid.quiet", n_bad, 32'd0);

    // wb_ex / ertn without wb_valid are ignored.
    wb_valid = 1'b0; wb_ex = 1'b1; ertn_in = 1'b1;
    n_bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_bad += int'(busy) + int'(ex_commit) + int'(ertn_commit) + int'(flush);
    end
    check_eq("novalid.quiet", n_bad, 32'd0);
    wb_ex = 1'b0; ertn_in = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
